// File: rtl/pc_sequencer_rv32i.sv
`default_nettype none
// ============================================================================
// pc_sequencer_rv32i : multi-cycle fetch / next-PC controller for the RV32I core
// Optional feature macro: PCSEQ_MISALIGN_TRAP_EN (trap on misaligned next PC)
// Revision: 1.0
// ============================================================================
module pc_sequencer_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          WCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    input  logic              instr_ready,
    input  logic [31:0]       PC_in,
    input  logic              hold,
    output logic              fetch_err,
    output logic [1:0]        err_code,
    output logic [WCNT_W-1:0] wait_cnt
);

    localparam int                TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            r_state;
    logic [TMO_W-1:0]  r_tmo;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic              r_req;
    logic              r_valid;
    logic              r_err;
    logic [1:0]        r_code;
    logic [WCNT_W-1:0] r_wcnt;

    logic w_retire;
    assign w_retire = (r_state == S_ISSUE) && instr_ready && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_tmo   <= '0;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (!hold) begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // An ack on the last allowed cycle still completes the fetch.
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_tmo   <= '0;
                        r_state <= S_ISSUE;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        if (r_wcnt != WCNT_MAX) begin
                            r_wcnt <= r_wcnt + WCNT_W'(1);
                        end
                        if (r_tmo == TMO_LAST) begin
                            r_state <= S_ERR;
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                            r_code  <= 2'b01;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_retire) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
                        if (PC_in[1:0] != 2'b00) begin
                            r_state <= S_ERR;
                            r_valid <= 1'b0;
                            r_err   <= 1'b1;
                            r_code  <= 2'b10;
                        end else begin
                            r_pc    <= PC_in;
                            r_state <= S_FETCH;
                            r_valid <= 1'b0;
                            r_req   <= 1'b1;
                        end
`else
                        r_pc    <= PC_in & ~32'h3;
                        r_state <= S_FETCH;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
`endif
                    end
                end
                S_ERR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;
    assign err_code    = r_code;
    assign wait_cnt    = r_wcnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer_rv32i.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer_rv32i : directed scenarios plus randomized run against a
// transaction-level model of the fetch/retire sequencer.  Revision: 1.0
// ============================================================================
module tb_pc_sequencer_rv32i;

    localparam int TIMEOUT = 16;
    localparam int WCNT_W  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready = 1'b0;
    logic [31:0] PC_in = '0;
    logic        hold = 1'b0;
    logic        fetch_err;
    logic [1:0]  err_code;
    logic [WCNT_W-1:0] wait_cnt;

    int tests_run = 0;
    int fails = 0;

    // Reference model: what execute currently holds, how many fetch attempts failed.
    logic [31:0] m_pc, m_instr;
    logic        m_boot, m_have, m_dead;
    logic [1:0]  m_code;
    int          m_tries, m_wait;

    pc_sequencer_rv32i #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT), .WCNT_W(WCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .instr_ready(instr_ready),
        .PC_in(PC_in), .hold(hold), .fetch_err(fetch_err), .err_code(err_code),
        .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_boot = 1'b1; m_have = 1'b0; m_dead = 1'b0;
        m_code = 2'b00; m_tries = 0; m_wait = 0;
    endtask

    task automatic model_step(input logic a, input logic [31:0] d, input logic r,
                              input logic [31:0] p, input logic h);
        if (m_dead) return;
        if (m_boot) begin
            if (!h) m_boot = 1'b0;
            return;
        end
        if (!m_have) begin
            if (a) begin
                m_instr = d; m_have = 1'b1; m_tries = 0;
            end else begin
                if (m_wait < 255) m_wait++;
                m_tries++;
                if (m_tries == TIMEOUT) begin m_dead = 1'b1; m_code = 2'b01; end
            end
        end else if (r && !h) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
            if (p[1:0] != 2'b00) begin m_dead = 1'b1; m_code = 2'b10; return; end
`endif
            m_pc = {p[31:2], 2'b00};
            m_have = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic a, input logic [31:0] d, input logic r,
                         input logic [31:0] p, input logic h);
        imem_ack = a; imem_rdata = d; instr_ready = r; PC_in = p; hold = h;
        model_step(a, d, r, p, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_ack = 1'b0; instr_ready = 1'b0; hold = 1'b0; PC_in = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({imem_req, instr_valid, fetch_err, err_code, wait_cnt, pc, instr} !== {5'b0, 8'd0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: got req=%b valid=%b err=%b code=%b wcnt=%0d pc=%h instr=%h, want all zero",
                     imem_req, instr_valid, fetch_err, err_code, wait_cnt, pc, instr);
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || wait_cnt !== 8'd2) begin
            fails++;
            $display("FAIL boot_fetch: got req=%b addr=%h wcnt=%0d, want req=1 addr=0 wcnt=2", imem_req, imem_addr, wait_cnt);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 || wait_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_fetch: got req=%b pc=%h valid=%b wcnt=%0d, want 0/0/0/0", imem_req, pc, instr_valid, wait_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'hDEAD_BEEF, 0, 0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            fails++;
            $display("FAIL late_ack_ignored: got req=%b valid=%b instr=%h, want 1/0/0", imem_req, instr_valid, instr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] d;
        do_reset();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL stream_fetch%0d: got req=%b addr=%h valid=%b, want 1/%h/0", i, imem_req, imem_addr, instr_valid, 32'(4 * i));
            end
            d = $urandom;
            drive(1, d, 0, 0, 0);
            tests_run++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== d || pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin
                fails++;
                $display("FAIL stream_issue%0d: got valid=%b req=%b instr=%h pc=%h pc4=%h, want 1/0/%h/%h/%h",
                         i, instr_valid, imem_req, instr, pc, pc_plus4, d, 32'(4 * i), 32'(4 * i + 4));
            end
            drive(0, 0, 1, 32'(4 * i + 4), 0);
        end
        tests_run++;
        if (wait_cnt !== 8'd0) begin
            fails++;
            $display("FAIL stream_wait_cnt: got %0d, want 0", wait_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 32'h13, 0, 0, 0);
        drive(0, 0, 1, 32'h100, 0);
        drive(1, 32'h6F, 0, 0, 0);
        tests_run++;
        if (pc !== 32'h100 || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL branch_pc: got pc=%h valid=%b, want 100/1", pc, instr_valid);
        end
        drive(0, 0, 1, 32'h80, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            fails++;
            $display("FAIL branch_target: got req=%b addr=%h, want 1/00000080", imem_req, imem_addr);
        end
        drive(1, 32'h13, 0, 0, 0);
        drive(0, 0, 1, 32'hFFFF_FFFC, 0);
        tests_run++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            fails++;
            $display("FAIL pc_plus4_wrap: got pc=%h pc4=%h, want fffffffc/00000000", pc, pc_plus4);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 0, 0, 0, 0);
        tests_run++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: got err=%b req=%b, want 0/1", fetch_err, imem_req);
        end
        drive(1, 32'hCAFE_0001, 0, 0, 0);
        tests_run++;
        if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hCAFE_0001 || wait_cnt !== 8'd15) begin
            fails++;
            $display("FAIL timeout_ack_wins: got err=%b valid=%b instr=%h wcnt=%0d, want 0/1/cafe0001/15",
                     fetch_err, instr_valid, instr, wait_cnt);
        end
        drive(0, 0, 1, 32'h40, 0);
        for (int i = 0; i < TIMEOUT; i++) drive(0, 0, 0, 0, 0);
        tests_run++;
        if (fetch_err !== 1'b1 || err_code !== 2'b01 || imem_req !== 1'b0 || instr_valid !== 1'b0 || wait_cnt !== 8'd31) begin
            fails++;
            $display("FAIL timeout_err: got err=%b code=%b req=%b valid=%b wcnt=%0d, want 1/01/0/0/31",
                     fetch_err, err_code, imem_req, instr_valid, wait_cnt);
        end
        drive(1, 32'h1234_5678, 1, 32'h200, 0);
        drive(0, 0, 1, 32'h200, 0);
        tests_run++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40 || instr !== 32'hCAFE_0001) begin
            fails++;
            $display("FAIL err_terminal: got err=%b req=%b valid=%b pc=%h instr=%h, want 1/0/0/40/cafe0001",
                     fetch_err, imem_req, instr_valid, pc, instr);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(0, 0, 0, 0, 1);
        tests_run++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL hold_boot: got req=%b, want 0", imem_req);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 32'hA5A5_0000, 0, 0, 1);
        tests_run++;
        if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0000) begin
            fails++;
            $display("FAIL hold_fetch_ignored: got valid=%b instr=%h, want 1/a5a50000", instr_valid, instr);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h5A5A_FFFF, 1, 32'h40, 1);
            tests_run++;
            if (pc !== 32'h0 || instr !== 32'hA5A5_0000 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL hold_issue%0d: got pc=%h instr=%h valid=%b req=%b, want 0/a5a50000/1/0",
                         i, pc, instr, instr_valid, imem_req);
            end
        end
        drive(0, 0, 1, 32'h40, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got req=%b addr=%h valid=%b, want 1/40/0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 32'h13, 0, 0, 0);
        drive(0, 0, 1, 32'h100, 0);
        drive(1, 32'h13, 0, 0, 0);
        drive(0, 0, 1, 32'h102, 0);
        tests_run++;
`ifdef PCSEQ_MISALIGN_TRAP_EN
        if (fetch_err !== 1'b1 || err_code !== 2'b10 || pc !== 32'h100 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL misalign_trap: got err=%b code=%b pc=%h req=%b valid=%b, want 1/10/100/0/0",
                     fetch_err, err_code, pc, imem_req, instr_valid);
        end
`else
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++;
            $display("FAIL misalign_align: got err=%b req=%b addr=%h, want 0/1/100", fetch_err, imem_req, imem_addr);
        end
`endif
    endtask

    task automatic test_random();
        logic [140:0] act, exp;
        int ackp, dead_cycles;
        logic [31:0] p;
        do_reset();
        ackp = 75;
        dead_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            act = {imem_req, instr_valid, fetch_err, err_code, wait_cnt, imem_addr, pc, pc_plus4, instr};
            exp = {!m_dead && !m_boot && !m_have, !m_dead && !m_boot && m_have, m_dead, m_code,
                   8'(m_wait), m_pc, m_pc, m_pc + 32'd4, m_instr};
            tests_run++;
            if (act !== exp) begin
                fails++;
                $display("FAIL random_cycle%0d: got %h, want %h", n, act, exp);
            end
            if (m_dead) dead_cycles++;
            if (dead_cycles > 3) begin
                do_reset();
                dead_cycles = 0;
                ackp = ($urandom_range(0, 3) == 0) ? 5 : 75;
            end else begin
                case ($urandom_range(0, 15))
                    0:       p = $urandom;
                    1:       p = 32'hFFFF_FFFC;
                    default: p = $urandom & 32'hFFFF_FFFC;
                endcase
                drive($urandom_range(0, 99) < ackp, $urandom, $urandom_range(0, 99) < 60, p,
                      $urandom_range(0, 99) < 20);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_branch();
        test_timeout();
        test_hold();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
